// File: rtl/div_unit_if.sv
// div_unit_if: request/result bundle between the execute stage (master)
// and the multi-cycle divider (slave).
interface div_unit_if #(
  parameter int DATA_W = 32
) ();
  logic                  signed_div_in;
  logic [DATA_W-1:0]     op1_in;
  logic [DATA_W-1:0]     op2_in;
  logic                  start_in;
  logic                  annul_in;
  logic [2*DATA_W-1:0]   result_out;
  logic                  ready_out;

  modport master (
    output signed_div_in, op1_in, op2_in, start_in, annul_in,
    input  result_out, ready_out
  );

  modport slave (
    input  signed_div_in, op1_in, op2_in, start_in, annul_in,
    output result_out, ready_out
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring 32/32 divider for DIV/DIVU.
// One quotient bit per cycle. The result is {remainder, quotient}.
// Optional macro DIV_ZERO_FLAG_EN adds the div_zero_out flag port.
module div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  div_unit_if.slave  bus
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic       div_zero_out
`endif
);

  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   dividend_q, dividend_d;
  logic [DATA_W-1:0]   divisor_q, divisor_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quot_q, quot_d;
  logic                q_neg_q, q_neg_d;
  logic                r_neg_q, r_neg_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;
  logic                dz_q, dz_d;

  logic [DATA_W-1:0]   op1_abs, op2_abs;
  logic                op1_neg, op2_neg;
  logic [DATA_W+1:0]   trial;
  logic [DATA_W-1:0]   rem_next, quot_next, rem_fix, quot_fix;

  assign op1_neg = bus.signed_div_in & bus.op1_in[DATA_W-1];
  assign op2_neg = bus.signed_div_in & bus.op2_in[DATA_W-1];
  assign op1_abs = op1_neg ? (~bus.op1_in + 1'b1) : bus.op1_in;
  assign op2_abs = op2_neg ? (~bus.op2_in + 1'b1) : bus.op2_in;

  // One restoring step: subtract the divisor from the shifted partial
  // remainder; the extra top bit of trial is the borrow (negative result).
  assign trial     = {1'b0, rem_q, dividend_q[DATA_W-1]} - {2'b00, divisor_q};
  assign rem_next  = trial[DATA_W+1] ? {rem_q[DATA_W-2:0], dividend_q[DATA_W-1]}
                                     : trial[DATA_W-1:0];
  assign quot_next = {quot_q[DATA_W-2:0], ~trial[DATA_W+1]};
  assign rem_fix   = r_neg_q ? (~rem_next + 1'b1) : rem_next;
  assign quot_fix  = q_neg_q ? (~quot_next + 1'b1) : quot_next;

  // State, datapath and output registers; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FREE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
      dz_q       <= dz_d;
    end
  end

  // Next-state and next-register values for the divider sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    result_d   = result_q;
    ready_d    = ready_q;
    dz_d       = dz_q;
    case (state_q)
      FREE: begin
        result_d = '0;
        ready_d  = 1'b0;
        dz_d     = 1'b0;
        if (bus.start_in && !bus.annul_in) begin
          dividend_d = op1_abs;
          divisor_d  = op2_abs;
          q_neg_d    = op1_neg ^ op2_neg;
          r_neg_d    = op1_neg;
          cnt_d      = '0;
          rem_d      = '0;
          quot_d     = '0;
          state_d    = (bus.op2_in == '0) ? BY_ZERO : ON;
        end
      end
      BY_ZERO: begin
        result_d = '0;
        if (bus.annul_in) begin
          ready_d = 1'b0;
          state_d = FREE;
        end else begin
          ready_d = 1'b1;
          dz_d    = 1'b1;
          state_d = END;
        end
      end
      ON: begin
        if (bus.annul_in) begin
          result_d = '0;
          ready_d  = 1'b0;
          state_d  = FREE;
        end else begin
          rem_d      = rem_next;
          quot_d     = quot_next;
          dividend_d = dividend_q << 1;
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            result_d = {rem_fix, quot_fix};
            ready_d  = 1'b1;
            state_d  = END;
          end
        end
      end
      END: begin
        if (!bus.start_in) begin
          result_d = '0;
          ready_d  = 1'b0;
          dz_d     = 1'b0;
          state_d  = FREE;
        end
      end
      default: state_d = FREE;
    endcase
  end

  assign bus.result_out = result_q;
  assign bus.ready_out  = ready_q;
`ifdef DIV_ZERO_FLAG_EN
  assign div_zero_out   = dz_q;
`endif

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32/32 integer divider that services DIV/DIVU from the execute stage.
- The execute stage is the initiator: it raises start, holds stall_req while waiting, and consumes the 64-bit {remainder, quotient} result for the HI/LO write.
- div_unit is the responder: radix-2 restoring division, one quotient bit per cycle, with a start/ready handshake and an annul input for pipeline flushes.

Parameters:
- DATA_W, 32, operand width; quotient and remainder are each DATA_W bits.
- CNT_W, 6, iteration counter width; must hold DATA_W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- signed_div_in  input  1  1 = signed DIV, 0 = unsigned DIVU
- op1_in  input  DATA_W  dividend
- op2_in  input  DATA_W  divisor
- start_in  input  1  request from execute; held high until the result has been consumed
- annul_in  input  1  flush; abandons any operation in progress
- result_out  output  2*DATA_W  [63:32] remainder (HI), [31:0] quotient (LO)
- ready_out  output  1  result_out valid

Behaviour:
- Clock and reset: one clock (clk); rst_n is asynchronous, active-low. While rst_n is low: state=FREE, result_out=0, ready_out=0, counter=0, internal registers=0. This applies at any point, including mid-division.
- States: FREE, BY_ZERO, ON, END. All outputs are registered.
- FREE:
  - If start_in=1 and annul_in=0 on an edge ("edge 0"), latch operands and sign info.
  - If signed: take |op1| and |op2| (two's-complement negate when bit 31=1). Record q_neg = op1[31]^op2[31] and r_neg = op1[31].
  - If op2_in==0, go to BY_ZERO; otherwise go to ON with cnt=0 and rem=0.
  - Otherwise stay in FREE with ready_out=0 and result_out=0.
- ON, one step per edge:
  - trial = {rem, dividend_msb} - divisor, computed at 33 bits.
  - If trial is non-negative: rem = trial[31:0] and shift in quotient bit 1. Otherwise shift the dividend bit into rem and shift in quotient bit 0.
  - cnt increments. On the edge where cnt==31, the final step completes and that same edge:
    - applies sign correction (quotient negated if q_neg, remainder negated if r_neg, signed only);
    - loads result_out, sets ready_out=1, and moves to END.
  - ready_out therefore first rises after edge 32.
- BY_ZERO: on the next edge (edge 1), result_out=0, ready_out=1, move to END.
- END:
  - Hold result_out and ready_out while start_in=1.
  - When start_in=0, on the next edge: FREE, ready_out=0, result_out=0.
- annul_in=1 in ON or BY_ZERO: next edge goes to FREE, ready_out=0, result_out=0, and the partial result is discarded. annul_in in END has no effect; normal consumption follows.
- Operand inputs may change after edge 0 without affecting the result.
- Signed 0x80000000 / 0xFFFFFFFF: magnitudes are 0x80000000 / 1. Both operands are negative, so no negation: quotient 0x80000000, remainder 0. No exception is raised.
- Arithmetic is modulo 2^32 for each half.

Optional Feature:
- Macro DIV_ZERO_FLAG_EN.
- Defined: adds output port div_zero_out (1 bit, reset 0). It is set together with ready_out when entering END from BY_ZERO and cleared whenever ready_out clears.
- Undefined: the port does not exist; divide-by-zero is visible only as result_out=0 with ready_out=1 after edge 1.

Test Plan:
1. Unsigned 100 / 7, start held high -> ready_out rises after edge 32; result_out = {0x00000002, 0x0000000E}. Hold 3 cycles; drop start -> ready_out=0, result_out=0 next edge.
2. Signed -7 (0xFFFFFFF9) / 2 -> result_out = {0xFFFFFFFF, 0xFFFFFFFD}. Signed 7 / -2 -> {0x00000001, 0xFFFFFFFD}.
3. op2_in=0, op1_in=0x1234 -> ready_out after edge 1, result_out=0; div_zero_out=1 when DIV_ZERO_FLAG_EN is defined.
4. Unsigned 0xFFFFFFFF / 0x10, annul_in pulsed at edge 10 -> FREE at edge 11, ready_out stays 0. A new start of 9/3 on the following edge gives {0, 3} 32 edges later.
5. Signed 0x80000000 / 0xFFFFFFFF -> result_out = {0x00000000, 0x80000000}.
6. rst_n asserted low asynchronously at cycle 15 of a division -> ready_out=0 and result_out=0 immediately, without waiting for a clock edge. After release, the block is in FREE and accepts a new start.
